// File: rtl/vco_adc_pkg.sv
// ---------------------------------------------------------------------------
// vco_adc_pkg
//   Shared definitions for the VCO ADC Wishbone reader.
//   - Default register map of the ADC wrapper slave (base, status, data).
//   - Index of the sample-valid bit inside the status register.
//   - State encoding of the reader FSM.
// ---------------------------------------------------------------------------
package vco_adc_pkg;

    localparam logic [31:0] ADDR_BASE_DEF    = 32'h3000_0000;
    localparam logic [31:0] STATUS_OFS_DEF   = 32'h0000_0004;
    localparam logic [31:0] DATA_OFS_DEF     = 32'h0000_0008;
    localparam int          STATUS_VALID_BIT = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_STAT = 2'd1,
        GAP     = 2'd2,
        RD_DATA = 2'd3
    } state_e;

endpackage : vco_adc_pkg

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock show-ahead FIFO used as the ADC sample buffer.
//
//   Handshake: the head entry is presented on data_o whenever valid_o=1; an
//   entry is consumed on a clock edge where valid_o && pop_i. A push is taken
//   when the FIFO is not full, or when it is full and an entry leaves in the
//   same cycle. A pop while empty is ignored, so push+pop on an empty FIFO
//   makes the pushed word appear at the head on the next cycle.
//
//   Ports:
//     clk_i, rst_ni   clock, asynchronous active-low reset
//     push_i, data_i  write request and write data
//     pop_i           consumer ready
//     data_o          head entry (0 after reset)
//     valid_o         FIFO not empty
//     full_o          FIFO full
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         full_o
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when indices match.
    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic         empty;
    logic         pop_ok;
    logic         push_ok;

    always_comb begin
        empty   = (wr_q == rd_q);
        full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        valid_o = !empty;
        data_o  = mem_q[rd_q[AW-1:0]];
        pop_ok  = pop_i && !empty;
        push_ok = push_i && (!full_o || pop_ok);

        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push_ok) begin
            mem_d[wr_q[AW-1:0]] = data_i;
            wr_d                = wr_q + (AW+1)'(1);
        end
        if (pop_ok) begin
            rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule : sync_fifo

// File: rtl/wb_adc_reader.sv
// ---------------------------------------------------------------------------
// wb_adc_reader
//   Wishbone classic initiator that polls the VCO ADC wrapper. Every
//   period_i+1 cycles (while enable_i=1) it reads the status register; when
//   the sample-valid bit is set it waits one idle bus cycle and reads the
//   data register. Samples go into a small FIFO presented as a valid/ready
//   stream.
//
//   Optional feature (macro WB_ADC_READER_TIMEOUT_EN): an ack timeout of
//   TIMEOUT cycles aborts a hung bus cycle and sets the sticky err_o. With the
//   macro undefined the FSM waits indefinitely for ack and err_o is 0.
//
//   Ports:
//     wb_clk_i, wb_rst_ni    clock, asynchronous active-low reset
//     enable_i, period_i     polling enable and poll interval minus 1
//     wbm_*                  Wishbone classic master (read-only)
//     smp_data_o/valid_o     FIFO head sample / FIFO not empty
//     smp_ready_i            consumer accepts head sample
//     overflow_o             sticky: sample dropped on a full FIFO
//     err_o                  sticky: ack timeout
// ---------------------------------------------------------------------------
module wb_adc_reader
    import vco_adc_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE  = ADDR_BASE_DEF,
    parameter logic [31:0] STATUS_OFS = STATUS_OFS_DEF,
    parameter logic [31:0] DATA_OFS   = DATA_OFS_DEF,
    parameter int          PERIOD_W   = 16,
    parameter int          FIFO_DEPTH = 4,
    parameter int          TIMEOUT    = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                enable_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [3:0]          wbm_sel_o,
    output logic [31:0]         wbm_adr_o,
    output logic [31:0]         wbm_dat_o,
    input  logic [31:0]         wbm_dat_i,
    input  logic                wbm_ack_i,
    output logic [31:0]         smp_data_o,
    output logic                smp_valid_o,
    input  logic                smp_ready_i,
    output logic                overflow_o,
    output logic                err_o
);

    localparam logic [31:0] STAT_ADR = ADDR_BASE + STATUS_OFS;
    localparam logic [31:0] DATA_ADR = ADDR_BASE + DATA_OFS;

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] count_q, count_d;
    logic                cyc_q, cyc_d;
    logic [31:0]         adr_q, adr_d;
    logic                ovf_q, ovf_d;
    logic                tick;
    logic                push;
    logic                fifo_full;

`ifdef WB_ADC_READER_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] to_q, to_d;
    logic            err_q, err_d;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
`endif

    always_comb begin
        // Tick fires on the cycle the counter sits at period_i; ticks seen
        // outside IDLE are simply not acted on.
        tick    = enable_i && (count_q == period_i);
        count_d = (!enable_i || tick) ? '0 : count_q + PERIOD_W'(1);

        state_d = state_q;
        cyc_d   = cyc_q;
        adr_d   = adr_q;
        push    = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = RD_STAT;
                    cyc_d   = 1'b1;
                    adr_d   = STAT_ADR;
                end
            end
            RD_STAT: begin
                if (wbm_ack_i) begin
                    cyc_d   = 1'b0;
                    adr_d   = '0;
                    state_d = wbm_dat_i[STATUS_VALID_BIT] ? GAP : IDLE;
                end
            end
            GAP: begin
                state_d = RD_DATA;
                cyc_d   = 1'b1;
                adr_d   = DATA_ADR;
            end
            RD_DATA: begin
                if (wbm_ack_i) begin
                    push    = 1'b1;
                    cyc_d   = 1'b0;
                    adr_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                adr_d   = '0;
            end
        endcase

`ifdef WB_ADC_READER_TIMEOUT_EN
        // Counts wait cycles of the current bus cycle; the abort lands on the
        // TIMEOUT-th cycle without ack so cyc is high for exactly TIMEOUT cycles.
        to_d  = '0;
        err_d = err_q;
        if (cyc_q && !wbm_ack_i) begin
            to_d = to_q + TO_W'(1);
            if (to_q == TO_LAST) begin
                to_d    = '0;
                err_d   = 1'b1;
                state_d = IDLE;
                cyc_d   = 1'b0;
                adr_d   = '0;
                push    = 1'b0;
            end
        end
`endif

        // A full FIFO only drops the sample when nothing leaves this cycle.
        ovf_d = ovf_q | (push && fifo_full && !(smp_valid_o && smp_ready_i));
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            count_q <= '0;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef WB_ADC_READER_TIMEOUT_EN
            to_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            cyc_q   <= cyc_d;
            adr_q   <= adr_d;
            ovf_q   <= ovf_d;
`ifdef WB_ADC_READER_TIMEOUT_EN
            to_q    <= to_d;
            err_q   <= err_d;
`endif
        end
    end

    assign wbm_cyc_o  = cyc_q;
    assign wbm_stb_o  = cyc_q;
    assign wbm_we_o   = 1'b0;
    assign wbm_sel_o  = {4{cyc_q}};
    assign wbm_adr_o  = adr_q;
    assign wbm_dat_o  = '0;
    assign overflow_o = ovf_q;

`ifdef WB_ADC_READER_TIMEOUT_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    sync_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_ni),
        .push_i  (push),
        .data_i  (wbm_dat_i),
        .pop_i   (smp_ready_i),
        .data_o  (smp_data_o),
        .valid_o (smp_valid_o),
        .full_o  (fifo_full)
    );

endmodule : wb_adc_reader

// File: doc/wb_adc_reader.md
Name: wb_adc_reader

Overview:
Wishbone classic bus initiator that polls the VCO ADC wrapper's Wishbone slave registers. It is the reader for the wrapper's register interface.
- Every period_i+1 clocks it reads the status register. If the data-valid bit is set, it reads the data register.
- Captured samples are buffered in a small FIFO and presented on a valid/ready stream, used for LA/IO streaming or on-chip test.
- Sits in user_project_wrapper alongside vco_adc_wrapper, sharing wb_clk_i.

Parameters:
ADDR_BASE, 32'h3000_0000, base address of the ADC wrapper slave
STATUS_OFS, 32'h4, byte offset of the status register; bit 0 = sample valid
DATA_OFS, 32'h8, byte offset of the data register
PERIOD_W, 16, width of the poll-period input
FIFO_DEPTH, 4, sample FIFO entries; must be a power of 2, ≥2
TIMEOUT, 255, ack timeout in cycles (used only with the optional feature)

Ports:
wb_clk_i  in  1  Wishbone clock; the block's single clock
wb_rst_ni  in  1  asynchronous reset, active-low
enable_i  in  1  polling enable
period_i  in  PERIOD_W  poll interval minus 1, in cycles
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  write enable, always 0
wbm_sel_o  out  4  byte select, 4'hF during cycles
wbm_adr_o  out  32  address
wbm_dat_o  out  32  write data, always 0
wbm_dat_i  in  32  read data
wbm_ack_i  in  1  acknowledge
smp_data_o  out  32  FIFO head sample
smp_valid_o  out  1  FIFO not empty
smp_ready_i  in  1  consumer accepts the head sample
overflow_o  out  1  sticky: a sample was dropped because the FIFO was full
err_o  out  1  sticky: ack timeout (0 when the feature is compiled out)

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - all outputs 0; FSM=IDLE; tick counter=0; FIFO empty; sticky flags cleared.
  - Asserting reset mid-cycle drops cyc/stb immediately.
- Tick counter:
  - counts 0..period_i while enable_i=1, then wraps to 0 and raises a one-cycle tick.
  - held at 0 when enable_i=0.
  - period_i=0 gives a tick every cycle.
  - Ticks arriving while the FSM is not IDLE are discarded, not queued.
- FSM states: IDLE, RD_STAT, GAP, RD_DATA.
  - IDLE: on tick → RD_STAT.
  - RD_STAT: cyc=stb=1, adr=ADDR_BASE+STATUS_OFS, held stable until ack. On ack (same cycle) latch dat_i[0]; cyc/stb drop the next cycle. Bit 0=1 → GAP; bit 0=0 → IDLE.
  - GAP: one idle bus cycle with cyc=stb=0 → RD_DATA.
  - RD_DATA: cyc=stb=1, adr=ADDR_BASE+DATA_OFS, held until ack. On ack, push dat_i into the FIFO → IDLE.
  - Minimum poll-to-push latency: 4 cycles with zero-wait ack (ack in the first cycle of stb).
- enable_i falling mid-transaction: the current bus cycle and any pending data read complete, then IDLE. No new tick is issued.
- FIFO:
  - show-ahead; smp_valid_o = !empty; pop when smp_valid_o && smp_ready_i.
  - Push when full without a concurrent pop: sample dropped, overflow_o set until reset.
  - Push when full with a concurrent pop: accepted, occupancy unchanged.
  - Simultaneous push and pop when empty: the pushed sample appears at the head the next cycle; the pop is ignored because valid=0.
- Pointers are log2(FIFO_DEPTH)+1 bits with wrap-bit full/empty detection.

Optional Feature:
Macro WB_ADC_READER_TIMEOUT_EN.
- Defined:
  - an 8+ bit counter runs while cyc=1 and ack=0.
  - At TIMEOUT cycles: abort (cyc/stb drop), set err_o sticky, return to IDLE.
  - A timed-out status or data read pushes nothing.
- Undefined:
  - no counter; the FSM waits indefinitely for ack.
  - err_o tied to 0.

Decomposition:
- Package vco_adc_pkg holds:
  - STATUS_OFS/DATA_OFS defaults
  - the STATUS_VALID_BIT index (0)
  - the FSM state enum
- Sub-module sync_fifo, parameterised by data width and depth, implements the sample buffer.
- FSM, tick counter and timeout logic stay in wb_adc_reader.

Test Plan:
- period_i=9, enable_i=1, slave acks in 1 cycle, status=1, data=32'hDEADBEEF → RD_STAT at cycle 10 with adr 32'h3000_0004; RD_DATA adr 32'h3000_0008; smp_valid_o=1 with smp_data_o=32'hDEADBEEF 4 cycles after the tick.
- Status bit 0=0 → exactly one bus cycle per tick, no data read, smp_valid_o stays 0.
- smp_ready_i=0, status always 1, data = 1,2,3,4,5 → FIFO holds 1..4; the 5th is dropped; overflow_o=1; popping yields 1,2,3,4.
- Slave inserts 3 wait states on ack → cyc/stb/adr stay stable for 4 cycles; the sample is pushed after ack; no extra transaction.
- Reset asserted while stb=1 → outputs 0 immediately, FIFO empty; polling restarts from count 0 after release.
- With WB_ADC_READER_TIMEOUT_EN, TIMEOUT=255, ack never asserted → cyc drops after 255 cycles, err_o=1, FSM IDLE, next tick issues a new RD_STAT.
